// File: rtl/tank_pkg.sv
// tank_pkg: shared encodings for the tank controller, VGA renderer and timer.
//   dir_t    - facing direction (UP=0, RIGHT=1, DOWN=2, LEFT=3)
//   ST_*     - game state encoding driven by the top-level state machine
//   fsm_t    - movement FSM states of tank_ctrl
//   abs8     - magnitude of a signed 8-bit difference, used for overlap tests
package tank_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    localparam logic [1:0] ST_INIT  = 2'b00;
    localparam logic [1:0] ST_PLAY  = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;
    localparam logic [1:0] ST_END   = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        COMMIT
    } fsm_t;

    function automatic logic [7:0] abs8(input logic signed [7:0] v);
        return v[7] ? 8'(-v) : 8'(v);
    endfunction

endpackage

// File: rtl/tank_collide.sv
// tank_collide: combinational legality check for a square tank candidate cell.
//   cx, cy  in  7 signed  candidate top-left cell (may be -1 after a step off the edge)
//   ox, oy  in  6         other tank top-left cell
//   legal   out 1         candidate lies inside the map and does not overlap the other tank
module tank_collide
    import tank_pkg::*;
#(
    parameter int TANK_SZ = 2,
    parameter int MAP_W   = 40,
    parameter int MAP_H   = 30
)(
    input  logic signed [6:0] cx,
    input  logic signed [6:0] cy,
    input  logic        [5:0] ox,
    input  logic        [5:0] oy,
    output logic              legal
);

    localparam logic signed [6:0] X_MAX = 7'(MAP_W - TANK_SZ);
    localparam logic signed [6:0] Y_MAX = 7'(MAP_H - TANK_SZ);
    localparam logic        [7:0] SZ    = 8'(TANK_SZ);

    logic in_map;
    logic overlap;

    // Two equal squares overlap exactly when both axis distances are below the edge length.
    always_comb begin
        in_map  = cx >= 7'sd0 && cx <= X_MAX && cy >= 7'sd0 && cy <= Y_MAX;
        overlap = abs8({cx[6], cx} - {2'b00, ox}) < SZ && abs8({cy[6], cy} - {2'b00, oy}) < SZ;
        legal   = in_map && !overlap;
    end

endmodule

// File: rtl/tank_ctrl.sv
// tank_ctrl: per-player tank motion and fire controller.
//   clk              in  1  25 MHz system clock
//   rst_n            in  1  asynchronous active-low reset
//   i_top_state      in  2  game state (ST_INIT / ST_PLAY / ST_PAUSE / ST_END)
//   i_VGA_buzy       in  1  renderer busy; position/direction must not change
//   i_up..i_right    in  1  debounced direction buttons, active-high
//   i_fire           in  1  debounced fire button, active-high
//   i_other_x/_y     in  6  opponent tank top-left cell
//   i_bullet_active  in  1  this player's bullet is still in flight
//   o_x, o_y         out 6  tank top-left cell
//   o_dir            out 2  facing direction (dir_t encoding)
//   o_fire           out 1  one-cycle shot request
module tank_ctrl
    import tank_pkg::*;
#(
    parameter logic [5:0] INIT_X        = 6'd2,
    parameter logic [5:0] INIT_Y        = 6'd2,
    parameter logic [1:0] INIT_DIR      = 2'd0,
    parameter int         MAP_W         = 40,
    parameter int         MAP_H         = 30,
    parameter int         TANK_SZ       = 2,
    parameter int         MOVE_CYCLES   = 2_500_000,
    parameter int         FIRE_COOLDOWN = 4
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_top_state,
    input  logic       i_VGA_buzy,
    input  logic       i_up,
    input  logic       i_down,
    input  logic       i_left,
    input  logic       i_right,
    input  logic       i_fire,
    input  logic [5:0] i_other_x,
    input  logic [5:0] i_other_y,
    input  logic       i_bullet_active,
    output logic [5:0] o_x,
    output logic [5:0] o_y,
    output logic [1:0] o_dir,
    output logic       o_fire
);

    localparam int CW = MOVE_CYCLES > 1 ? $clog2(MOVE_CYCLES) : 1;
    localparam int KW = FIRE_COOLDOWN > 0 ? $clog2(FIRE_COOLDOWN + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MOVE_CYCLES - 1);
    localparam logic [KW-1:0] CD_LOAD = KW'(FIRE_COOLDOWN);

    logic        [CW-1:0] cnt;
    logic        [KW-1:0] cooldown;
    fsm_t                 state;
    logic                 fire_prev;
    logic        [5:0]    nx;
    logic        [5:0]    ny;
    logic        [1:0]    ndir;
    logic                 play;
    logic                 init;
    logic                 tick;
    logic                 shot;
    logic                 req;
    logic                 mv;
    dir_t                 req_dir;
    logic signed [6:0]    cx;
    logic signed [6:0]    cy;
    logic                 legal;

    // A request in a new direction only turns; a request in the current direction steps.
    // Stepping left/up from cell 0 yields -1 in 7-bit signed, which the bounds check rejects.
    always_comb begin
        play    = i_top_state == ST_PLAY;
        init    = i_top_state == ST_INIT;
        tick    = play && cnt == CNT_MAX;
        shot    = play && i_fire && !fire_prev && cooldown == '0 && !i_bullet_active;
        req     = i_up || i_down || i_left || i_right;
        req_dir = i_up ? DIR_UP : i_down ? DIR_DOWN : i_left ? DIR_LEFT : DIR_RIGHT;
        mv      = req && req_dir == o_dir;
        cx      = {1'b0, o_x} + (mv && req_dir == DIR_RIGHT ? 7'sd1 : 7'sd0)
                              - (mv && req_dir == DIR_LEFT  ? 7'sd1 : 7'sd0);
        cy      = {1'b0, o_y} + (mv && req_dir == DIR_DOWN  ? 7'sd1 : 7'sd0)
                              - (mv && req_dir == DIR_UP    ? 7'sd1 : 7'sd0);
    end

    tank_collide #(
        .TANK_SZ (TANK_SZ),
        .MAP_W   (MAP_W),
        .MAP_H   (MAP_H)
    ) u_collide (
        .cx    (cx),
        .cy    (cy),
        .ox    (i_other_x),
        .oy    (i_other_y),
        .legal (legal)
    );

    // Ticks arriving outside IDLE (e.g. while COMMIT waits on VGA) are simply dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            cooldown  <= '0;
            state     <= IDLE;
            fire_prev <= 1'b0;
            o_fire    <= 1'b0;
            o_x       <= INIT_X;
            o_y       <= INIT_Y;
            o_dir     <= INIT_DIR;
            nx        <= INIT_X;
            ny        <= INIT_Y;
            ndir      <= INIT_DIR;
        end else begin
            fire_prev <= i_fire;
            o_fire    <= shot;
            if (init) begin
                cnt      <= '0;
                cooldown <= '0;
                state    <= IDLE;
                o_x      <= INIT_X;
                o_y      <= INIT_Y;
                o_dir    <= INIT_DIR;
                nx       <= INIT_X;
                ny       <= INIT_Y;
                ndir     <= INIT_DIR;
            end else if (play) begin
                cnt      <= tick ? '0 : cnt + CW'(1);
                cooldown <= shot ? CD_LOAD : (tick && cooldown != '0) ? cooldown - KW'(1) : cooldown;
                case (state)
                    IDLE: state <= tick ? EVAL : IDLE;
                    EVAL: begin
                        nx    <= req && legal ? cx[5:0] : o_x;
                        ny    <= req && legal ? cy[5:0] : o_y;
                        ndir  <= req && legal ? req_dir : o_dir;
                        state <= COMMIT;
                    end
                    COMMIT: begin
                        if (!i_VGA_buzy) begin
                            o_x   <= nx;
                            o_y   <= ny;
                            o_dir <= ndir;
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tank_ctrl.sv
// tb_tank_ctrl: directed self-checking bench for tank_ctrl (MOVE_CYCLES=8, FIRE_COOLDOWN=2).
module tb_tank_ctrl;
    import tank_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] top_state = ST_INIT;
    logic       buzy = 1'b0;
    logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
    logic       fire = 1'b0;
    logic [5:0] other_x = 6'd30, other_y = 6'd20;
    logic       bullet = 1'b0;
    logic [5:0] o_x, o_y;
    logic [1:0] o_dir;
    logic       o_fire;

    int vectors = 0;
    int miscompares = 0;
    logic [5:0] ex_x = 6'd2, ex_y = 6'd2;
    logic [1:0] ex_dir = 2'd0;

    always #5 clk = ~clk;

    tank_ctrl #(
        .MOVE_CYCLES   (8),
        .FIRE_COOLDOWN (2)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_top_state     (top_state),
        .i_VGA_buzy      (buzy),
        .i_up            (up),
        .i_down          (down),
        .i_left          (left),
        .i_right         (right),
        .i_fire          (fire),
        .i_other_x       (other_x),
        .i_other_y       (other_y),
        .i_bullet_active (bullet),
        .o_x             (o_x),
        .o_y             (o_y),
        .o_dir           (o_dir),
        .o_fire          (o_fire)
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_pos(input string tag, input logic [5:0] x, input logic [5:0] y, input logic [1:0] d);
        chk({tag, "_x"}, 16'(o_x), 16'(x));
        chk({tag, "_y"}, 16'(o_y), 16'(y));
        chk({tag, "_dir"}, 16'(o_dir), 16'(d));
    endtask

    task automatic btn(input logic u, input logic d, input logic l, input logic r);
        up = u; down = d; left = l; right = r;
    endtask

    // Entered 2 cycles after a tick; the next tick is 6 edges later, its commit 8 edges later.
    task automatic step(input string tag, input logic [5:0] x, input logic [5:0] y, input logic [1:0] d);
        cyc(7);
        chk_pos({tag, "_pre"}, ex_x, ex_y, ex_dir);
        cyc(1);
        chk_pos({tag, "_post"}, x, y, d);
        ex_x = x; ex_y = y; ex_dir = d;
    endtask

    initial begin
        cyc(2);
        chk_pos("reset", 6'd2, 6'd2, DIR_UP);
        chk("reset_fire", 16'(o_fire), 16'd0);
        rst_n = 1'b1;
        cyc(2);
        chk_pos("init_hold", 6'd2, 6'd2, DIR_UP);
        top_state = ST_PLAY;
        cyc(2);
        btn(0, 0, 0, 1);
        step("turn_r", 6'd2, 6'd2, DIR_RIGHT);
        step("mv_r1", 6'd3, 6'd2, DIR_RIGHT);
        step("mv_r2", 6'd4, 6'd2, DIR_RIGHT);
        step("mv_r3", 6'd5, 6'd2, DIR_RIGHT);
        btn(1, 0, 0, 0);
        step("turn_up", 6'd5, 6'd2, DIR_UP);
        btn(0, 0, 1, 0);
        step("turn_l", 6'd5, 6'd2, DIR_LEFT);
        step("mv_l", 6'd4, 6'd2, DIR_LEFT);
        other_x = 6'd2; other_y = 6'd2;
        step("blk_same_row", 6'd4, 6'd2, DIR_LEFT);
        other_y = 6'd3;
        step("blk_offset", 6'd4, 6'd2, DIR_LEFT);
        other_y = 6'd4;
        step("clear_diag", 6'd3, 6'd2, DIR_LEFT);
        other_x = 6'd30; other_y = 6'd20;
        btn(0, 0, 1, 1);
        step("prio_lr", 6'd2, 6'd2, DIR_LEFT);
        btn(0, 0, 0, 1);
        step("turn_r2", 6'd2, 6'd2, DIR_RIGHT);
        for (int i = 3; i <= 38; i++) step("run_r", 6'(i), 6'd2, DIR_RIGHT);
        step("bound_r1", 6'd38, 6'd2, DIR_RIGHT);
        step("bound_r2", 6'd38, 6'd2, DIR_RIGHT);
        btn(1, 1, 0, 0);
        step("prio_ud", 6'd38, 6'd2, DIR_UP);
        step("mv_u1", 6'd38, 6'd1, DIR_UP);
        step("mv_u2", 6'd38, 6'd0, DIR_UP);
        step("bound_u", 6'd38, 6'd0, DIR_UP);
        btn(0, 1, 0, 0);
        buzy = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            cyc(1);
            chk_pos("buzy_hold", 6'd38, 6'd0, DIR_UP);
        end
        buzy = 1'b0;
        btn(0, 0, 0, 0);
        cyc(1);
        chk_pos("buzy_release", 6'd38, 6'd0, DIR_DOWN);
        cyc(3);
        chk_pos("buzy_once", 6'd38, 6'd0, DIR_DOWN);
        fire = 1'b1;
        cyc(1);
        chk("fire1", 16'(o_fire), 16'd1);
        cyc(1);
        chk("fire1_width", 16'(o_fire), 16'd0);
        fire = 1'b0;
        cyc(6);
        fire = 1'b1;
        cyc(1);
        chk("fire_cooldown", 16'(o_fire), 16'd0);
        cyc(1);
        chk("fire_cooldown2", 16'(o_fire), 16'd0);
        fire = 1'b0;
        cyc(6);
        fire = 1'b1;
        cyc(1);
        chk("fire2", 16'(o_fire), 16'd1);
        cyc(1);
        chk("fire2_width", 16'(o_fire), 16'd0);
        fire = 1'b0;
        bullet = 1'b1;
        cyc(14);
        fire = 1'b1;
        cyc(1);
        chk("fire_bullet", 16'(o_fire), 16'd0);
        cyc(1);
        chk("fire_bullet2", 16'(o_fire), 16'd0);
        fire = 1'b0;
        bullet = 1'b0;
        btn(0, 0, 0, 1);
        top_state = ST_PAUSE;
        cyc(20);
        chk_pos("pause_frozen", 6'd38, 6'd0, DIR_DOWN);
        top_state = ST_INIT;
        cyc(1);
        chk_pos("init_return", 6'd2, 6'd2, DIR_UP);
        top_state = ST_PLAY;
        ex_x = 6'd2; ex_y = 6'd2; ex_dir = DIR_UP;
        cyc(2);
        step("re_turn", 6'd2, 6'd2, DIR_RIGHT);
        step("re_mv", 6'd3, 6'd2, DIR_RIGHT);
        btn(0, 1, 0, 0);
        buzy = 1'b1;
        cyc(8);
        chk_pos("commit_wait", 6'd3, 6'd2, DIR_RIGHT);
        #2;
        rst_n = 1'b0;
        #1;
        chk_pos("async_rst", 6'd2, 6'd2, DIR_UP);
        chk("async_rst_fire", 16'(o_fire), 16'd0);
        cyc(2);
        rst_n = 1'b1;
        buzy = 1'b0;
        btn(0, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tank_ctrl.md
Name: tank_ctrl

Overview:
Per-player tank motion and fire controller; consumes one Joystick's button levels and produces the tank position and direction that feed the VGA renderer's i_tankN_x/i_tankN_y/i_tankN_dir inputs. One instance per player. Movement is rate-limited by a cycle counter, gated by the game state, bounded by the map, and blocked by the other tank. Register updates are held off while VGA reports busy, so a frame never shows a torn position.

Parameters:
INIT_X, 6'd2, start column (top-left cell of the tank)
INIT_Y, 6'd2, start row
INIT_DIR, 2'd0, start direction (package encoding)
MAP_W, 40, map width in cells
MAP_H, 30, map height in cells
TANK_SZ, 2, tank edge length in cells (square)
MOVE_CYCLES, 2_500_000, clk cycles per move step (100 ms at 25 MHz)
FIRE_COOLDOWN, 4, move steps after a shot before the next shot is accepted

Ports:
clk  in  1  system clock, the 25 MHz VGA/timer domain
rst_n  in  1  asynchronous active-low reset
i_top_state  in  2  game state, package encoding
i_VGA_buzy  in  1  high while VGA is scanning active area; no output update allowed
i_up, i_down, i_left, i_right  in  1 each  debounced button levels, active-high
i_fire  in  1  debounced fire level, active-high
i_other_x, i_other_y  in  6 each  opponent tank top-left cell
i_bullet_active  in  1  this player's bullet still in flight
o_x, o_y  out  6 each  tank top-left cell
o_dir  out  2  facing direction
o_fire  out  1  one-cycle shot request

Behaviour:
- Reset: o_x=INIT_X, o_y=INIT_Y, o_dir=INIT_DIR, o_fire=0, step counter=0, cooldown=0, FSM=IDLE, fire edge register=0.
- i_top_state==ST_INIT: outputs forced to INIT values synchronously, counters cleared, FSM=IDLE. ST_PAUSE/ST_END: everything frozen, counter holds. Only ST_PLAY advances.
- Step counter counts 0..MOVE_CYCLES-1 in ST_PLAY; the wrap cycle is the step tick.
- FSM IDLE -> EVAL on the step tick. EVAL (1 cycle): sample buttons; priority up>down>left>right; none pressed -> no request. Request dir != o_dir -> candidate = turn only (position unchanged). Request dir == o_dir -> candidate = position +/-1 on the axis.
- Bounds: candidate rejected if x<0, x>MAP_W-TANK_SZ, y<0, or y>MAP_H-TANK_SZ (compute in 7-bit signed; no wrap-around). Collision: rejected if |cx-i_other_x|<TANK_SZ and |cy-i_other_y|<TANK_SZ. A rejected move keeps position and direction.
- EVAL -> COMMIT. COMMIT writes o_x/o_y/o_dir in the first cycle with i_VGA_buzy=0, then -> IDLE. If a step tick arrives while in COMMIT, it is dropped and the counter still wraps; no queueing.
- Fire: rising edge of i_fire (registered previous level) in ST_PLAY with cooldown==0 and i_bullet_active==0 -> o_fire=1 for exactly one cycle; cooldown loaded with FIRE_COOLDOWN and decremented on each step tick. An edge that is blocked is discarded, not remembered. Fire is independent of the movement FSM and of i_VGA_buzy.
- Latency: the earliest position change is 2 cycles after the step tick (EVAL, COMMIT) when VGA is idle.
- Async reset mid-COMMIT: outputs return to INIT values immediately.

Decomposition:
- tank_pkg: dir_t enum (DIR_UP=0, DIR_RIGHT=1, DIR_DOWN=2, DIR_LEFT=3), game state constants (ST_INIT=2'b00, ST_PLAY=2'b01, ST_PAUSE=2'b10, ST_END=2'b11), FSM state enum (IDLE, EVAL, COMMIT). The VGA block and timer import the same package.
- One sub-module: tank_collide. It is combinational and takes the candidate, the other tank, TANK_SZ, MAP_W and MAP_H, and outputs a legal flag. A future bullet-hit check reuses it.

Test Plan:
- MOVE_CYCLES=8, ST_PLAY, i_right held, o_dir=RIGHT, x=2 -> x advances 3,4,5 on successive steps, each 2 cycles after the tick.
- o_dir=UP, i_left pulsed for one step -> o_dir=LEFT and x unchanged. Holding it for the next step -> x-1.
- x=38, TANK_SZ=2, MAP_W=40, dir RIGHT, i_right held -> x stays 38. Likewise y=0 with i_up held -> y stays 0.
- Self (10,10) facing RIGHT, other (12,10), i_right held -> x stays 10. Move other to (12,12) -> x becomes 11.
- i_VGA_buzy held high for 20 cycles across a tick -> outputs are stable until the first low cycle, then update once.
- FIRE_COOLDOWN=2: i_fire rises -> o_fire is one cycle wide. A second rise 1 step later -> no pulse. A rise after 2 steps -> pulse. With i_bullet_active=1 -> never a pulse.
- Switch to ST_INIT from (20,15) -> outputs return to (INIT_X, INIT_Y, INIT_DIR) on the next cycle.
